network_router_np: RTL and testbench
====================================

NETWORK_ROUTER_NP -- requirements
Module: network_router_np

Interface
REQ-001 Parameter NUM_PORTS, default 4, SHALL set the number of LAN output ports (2..16).
REQ-002 Parameter DEST_IP_LEN, default 32, SHALL set the destination IP field width.
REQ-003 Parameter PAYLOAD_LEN, default 32, SHALL set the payload field width.
REQ-004 Parameter QUEUE_DEPTH, default 4, SHALL set per-port FIFO depth in packets (power of 2, >=2).
REQ-005 Derived CRC_LEN SHALL be max(DEST_IP_LEN, PAYLOAD_LEN) if the two differ, else DEST_IP_LEN+1; PKT_LEN = DEST_IP_LEN+PAYLOAD_LEN+CRC_LEN.
REQ-006 Packet format SHALL be {dest_ip, payload, crc} with dest_ip in the MSBs.
REQ-007 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 port_wan_vld  in  1  WAN packet valid.
REQ-010 port_wan  in  PKT_LEN  WAN packet.
REQ-011 port_wan_rdy  out  1  router can accept; transfer on vld && rdy at a rising edge.
REQ-012 port_en  in  NUM_PORTS  per-port link enable.
REQ-013 port_ip  in  NUM_PORTS*DEST_IP_LEN  per-port IP; port i at bits [i*DEST_IP_LEN +: DEST_IP_LEN].
REQ-014 port_pkt  out  NUM_PORTS*PKT_LEN  per-port FIFO head packet, same slicing rule.
REQ-015 port_vld  out  NUM_PORTS  per-port head valid.
REQ-016 port_rdy  in  NUM_PORTS  per-port downstream ready; pop on port_vld[i] && port_rdy[i].
REQ-017 congestion  out  NUM_PORTS  per-port FIFO full level.
REQ-018 pkt_drop, crc_error, link_down  out  1 each  single-cycle event pulses.
REQ-019 drop_cnt  out  16  saturating count of pkt_drop plus crc_error events.

Function
REQ-020 FSM SHALL have states IDLE, CHECK; port_wan_rdy = 1 only in IDLE.
REQ-021 IDLE: on vld && rdy, the packet is registered and the state goes to CHECK; otherwise stay IDLE.
REQ-022 CHECK lasts exactly one cycle, then the state returns to IDLE; accepted throughput is 1 packet per 2 cycles.
REQ-023 CRC check: (dest_ip + payload), zero-extended to CRC_LEN, modulo 2^CRC_LEN, SHALL equal the crc field.
REQ-024 Match: lowest index i with port_en[i]=1 and port_ip slice i == dest_ip; port_en and port_ip are sampled during CHECK.
REQ-025 At the CHECK-exit edge, if the CRC is bad, crc_error SHALL pulse the following cycle and nothing SHALL be enqueued (CRC error has priority over drop).
REQ-026 Else, if there is no match, pkt_drop SHALL pulse the following cycle.
REQ-027 Else, if FIFO i is full before any same-edge pop, pkt_drop SHALL pulse (no push even if a pop occurs that edge).
REQ-028 Else, the packet SHALL be pushed to FIFO i and port_vld[i] SHALL be 1 from the next cycle; the full packet, CRC included, is forwarded unchanged.
REQ-029 FIFOs SHALL be first-in first-out, with simultaneous push and pop allowed when not full; pointers wrap modulo QUEUE_DEPTH.
REQ-030 port_pkt slice i SHALL hold the FIFO head whenever port_vld[i]=1; pop with port_vld[i]=0 SHALL be ignored.
REQ-031 congestion[i] SHALL be 1 exactly when FIFO i holds QUEUE_DEPTH packets (registered count).
REQ-032 If port_en[i]=0 while FIFO i is non-empty, FIFO i SHALL be flushed at that edge and link_down SHALL pulse the next cycle; a push targeting i on that edge is impossible (REQ-024).
REQ-033 Multiple ports flushing on one edge SHALL produce one link_down pulse.
REQ-034 drop_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-035 With rst=1 at an edge: FSM->IDLE, FIFOs emptied, drop_cnt=0, all pulses/port_vld/congestion=0, and port_wan_rdy=0 while rst=1.
REQ-036 Reset mid-CHECK SHALL discard the in-flight packet with no event pulse; port_pkt after reset is don't-care.

Verification
REQ-037 Defaults; port_en=4'hF, IPs 1..4; send dest=3, payload=5, crc=8, port_rdy=F -> port_vld[2] 1 cycle after CHECK, port_pkt slice 2 equals input, no pulses.
REQ-038 Same packet with crc=9 -> crc_error one pulse, drop_cnt=1, no port_vld.
REQ-039 dest=7 (unmatched), valid CRC -> pkt_drop pulse, drop_cnt increments.
REQ-040 port_rdy[0]=0; send 5 valid packets to IP 1 -> first 4 queued, congestion[0]=1, 5th gives pkt_drop; raise port_rdy -> 4 packets popped in order.
REQ-041 2 packets queued on port 1, then port_en[1]=0 -> port_vld[1]=0 next cycle, one link_down pulse.
REQ-042 Duplicate IP 2 on ports 1 and 3 -> packet goes to port 1 only; rst asserted during CHECK -> no output, drop_cnt=0.

Source files
------------

// File: rtl/network_router_np.sv
// WAN-to-LAN packet router: accepts one packet per two cycles, checks its additive CRC,
// routes it by destination IP to the lowest-indexed enabled matching port, and queues it there.
module network_router_np #(
    parameter int NUM_PORTS   = 4,
    parameter int DEST_IP_LEN = 32,
    parameter int PAYLOAD_LEN = 32,
    parameter int QUEUE_DEPTH = 4,
    localparam int CRC_LEN = (DEST_IP_LEN != PAYLOAD_LEN) ?
                             ((DEST_IP_LEN > PAYLOAD_LEN) ? DEST_IP_LEN : PAYLOAD_LEN) :
                             (DEST_IP_LEN + 1),
    localparam int PKT_LEN = DEST_IP_LEN + PAYLOAD_LEN + CRC_LEN
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             port_wan_vld,
    input  logic [PKT_LEN-1:0]               port_wan,
    output logic                             port_wan_rdy,
    input  logic [NUM_PORTS-1:0]             port_en,
    input  logic [NUM_PORTS*DEST_IP_LEN-1:0] port_ip,
    output logic [NUM_PORTS*PKT_LEN-1:0]     port_pkt,
    output logic [NUM_PORTS-1:0]             port_vld,
    input  logic [NUM_PORTS-1:0]             port_rdy,
    output logic [NUM_PORTS-1:0]             congestion,
    output logic                             pkt_drop,
    output logic                             crc_error,
    output logic                             link_down,
    output logic [15:0]                      drop_cnt
);

    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W  = $clog2(QUEUE_DEPTH + 1);
    localparam int PORT_W = $clog2(NUM_PORTS);

    typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} state_t;

    state_t state_q, state_d;
    logic   check_done;

    logic [PKT_LEN-1:0]     pkt_q;
    logic [DEST_IP_LEN-1:0] pkt_dest;
    logic [PAYLOAD_LEN-1:0] pkt_payload;
    logic [CRC_LEN-1:0]     pkt_crc;
    logic [CRC_LEN-1:0]     crc_sum;

    logic              hit;
    logic [PORT_W-1:0] match_idx;
    logic              crc_bad, no_match, full_drop, push_en;

    logic [PKT_LEN-1:0]   mem [NUM_PORTS][QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr [NUM_PORTS];
    logic [PTR_W-1:0]     rd_ptr [NUM_PORTS];
    logic [CNT_W-1:0]     count  [NUM_PORTS];
    logic [NUM_PORTS-1:0] full, push, pop, flush;

    // Handshakes: a transfer happens at a rising edge where valid && ready are both 1;
    // valid never depends on ready, and ready on the WAN side is high only in IDLE.
    always_comb begin
        state_d      = state_q;
        port_wan_rdy = 1'b0;
        check_done   = 1'b0;
        case (state_q)
            IDLE: begin
                port_wan_rdy = !rst;
                if (port_wan_vld && port_wan_rdy) state_d = CHECK;
            end
            CHECK: begin
                check_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (port_wan_vld && port_wan_rdy) pkt_q <= port_wan;
    end

    always_comb begin
        pkt_dest    = pkt_q[PKT_LEN-1 -: DEST_IP_LEN];
        pkt_payload = pkt_q[CRC_LEN +: PAYLOAD_LEN];
        pkt_crc     = pkt_q[CRC_LEN-1:0];
        crc_sum     = CRC_LEN'(pkt_dest) + CRC_LEN'(pkt_payload);
    end

    // Scan downward so the lowest matching index is the one that sticks.
    always_comb begin
        hit       = 1'b0;
        match_idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (port_en[i] && (port_ip[i*DEST_IP_LEN +: DEST_IP_LEN] == pkt_dest)) begin
                hit       = 1'b1;
                match_idx = PORT_W'(i);
            end
        end
    end

    always_comb begin
        crc_bad   = check_done && (crc_sum != pkt_crc);
        no_match  = check_done && !crc_bad && !hit;
        full_drop = check_done && !crc_bad && hit && full[match_idx];
        push_en   = check_done && !crc_bad && hit && !full[match_idx] && !rst;
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            full[i]       = (count[i] == CNT_W'(QUEUE_DEPTH));
            port_vld[i]   = (count[i] != '0);
            congestion[i] = full[i];
            pop[i]        = port_vld[i] && port_rdy[i];
            flush[i]      = !port_en[i] && port_vld[i];
            push[i]       = push_en && (match_idx == PORT_W'(i));
            port_pkt[i*PKT_LEN +: PKT_LEN] = mem[i][rd_ptr[i]];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= pkt_q;
        end
    end

    // Flush beats pop: a disabled link drops its whole queue in one edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rst || flush[i]) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end else begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_drop  <= 1'b0;
            crc_error <= 1'b0;
            link_down <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            pkt_drop  <= no_match || full_drop;
            crc_error <= crc_bad;
            link_down <= |flush;
            if ((crc_bad || no_match || full_drop) && (drop_cnt != 16'hFFFF))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_network_router_np.sv
// Directed bench for network_router_np at default parameters: routing, CRC errors,
// unmatched drops, back-pressure and congestion, link-down flush, duplicate IPs and reset.
module tb_network_router_np;

    localparam int NP  = 4;
    localparam int IPW = 32;
    localparam int PLW = 32;
    localparam int CRW = 33;
    localparam int PKW = IPW + PLW + CRW;

    logic              clk = 1'b0;
    logic              rst;
    logic              port_wan_vld;
    logic [PKW-1:0]    port_wan;
    logic              port_wan_rdy;
    logic [NP-1:0]     port_en;
    logic [NP*IPW-1:0] port_ip;
    logic [NP*PKW-1:0] port_pkt;
    logic [NP-1:0]     port_vld;
    logic [NP-1:0]     port_rdy;
    logic [NP-1:0]     congestion;
    logic              pkt_drop, crc_error, link_down;
    logic [15:0]       drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [PKW-1:0] exp_q[$];
    logic [PKW-1:0] p;

    network_router_np dut (
        .clk(clk), .rst(rst),
        .port_wan_vld(port_wan_vld), .port_wan(port_wan), .port_wan_rdy(port_wan_rdy),
        .port_en(port_en), .port_ip(port_ip),
        .port_pkt(port_pkt), .port_vld(port_vld), .port_rdy(port_rdy),
        .congestion(congestion),
        .pkt_drop(pkt_drop), .crc_error(crc_error), .link_down(link_down),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [PKW-1:0] mk(input logic [31:0] d, input logic [31:0] pl,
                                          input logic [32:0] c);
        return {d, pl, c};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept edge, then CHECK-exit edge; returns 1 time unit after the CHECK exit.
    task automatic send(input logic [PKW-1:0] pkt);
        chk("wan_rdy_before_send", 128'(port_wan_rdy), 128'd1);
        port_wan_vld = 1'b1;
        port_wan     = pkt;
        step();
        port_wan_vld = 1'b0;
        chk("wan_rdy_in_check", 128'(port_wan_rdy), 128'd0);
        step();
    endtask

    task automatic chk_pulses(input string tag, input logic [2:0] exp);
        chk(tag, 128'({pkt_drop, crc_error, link_down}), 128'(exp));
    endtask

    initial begin
        rst          = 1'b1;
        port_wan_vld = 1'b0;
        port_wan     = '0;
        port_en      = 4'hF;
        port_ip      = {32'd4, 32'd3, 32'd2, 32'd1};
        port_rdy     = 4'hF;
        step();
        step();
        chk("reset_wan_rdy", 128'(port_wan_rdy), 128'd0);
        chk("reset_port_vld", 128'(port_vld), 128'd0);
        chk("reset_congestion", 128'(congestion), 128'd0);
        chk("reset_drop_cnt", 128'(drop_cnt), 128'd0);
        chk_pulses("reset_pulses", 3'b000);
        rst = 1'b0;
        #1;
        chk("idle_wan_rdy", 128'(port_wan_rdy), 128'd1);

        // Valid packet to IP 3 lands on port 2 untouched.
        p = mk(32'd3, 32'd5, 33'd8);
        send(p);
        chk("route_port_vld", 128'(port_vld), 128'b0100);
        chk("route_port_pkt", 128'(port_pkt[2*PKW +: PKW]), 128'(p));
        chk_pulses("route_no_pulse", 3'b000);
        chk("route_drop_cnt", 128'(drop_cnt), 128'd0);
        step();
        chk("route_popped", 128'(port_vld), 128'd0);

        // Bad CRC.
        send(mk(32'd3, 32'd5, 33'd9));
        chk_pulses("crc_pulse", 3'b010);
        chk("crc_drop_cnt", 128'(drop_cnt), 128'd1);
        chk("crc_no_vld", 128'(port_vld), 128'd0);
        step();
        chk_pulses("crc_pulse_end", 3'b000);

        // Unmatched destination.
        send(mk(32'd7, 32'd1, 33'd8));
        chk_pulses("nomatch_pulse", 3'b100);
        chk("nomatch_drop_cnt", 128'(drop_cnt), 128'd2);
        chk("nomatch_no_vld", 128'(port_vld), 128'd0);
        step();
        chk_pulses("nomatch_pulse_end", 3'b000);

        // Back-pressure on port 0: four fit, the fifth is dropped.
        port_rdy = 4'b1110;
        for (int k = 0; k < 4; k++) begin
            p = mk(32'd1, 32'(10 + k), 33'(11 + k));
            exp_q.push_back(p);
            send(p);
            chk_pulses("fill_no_pulse", 3'b000);
        end
        chk("fill_vld", 128'(port_vld), 128'b0001);
        chk("fill_congestion", 128'(congestion), 128'b0001);
        send(mk(32'd1, 32'd14, 33'd15));
        chk_pulses("full_drop_pulse", 3'b100);
        chk("full_drop_cnt", 128'(drop_cnt), 128'd3);
        chk("full_congestion", 128'(congestion), 128'b0001);
        port_rdy = 4'hF;
        for (int k = 0; k < 4; k++) begin
            chk("drain_vld", 128'(port_vld[0]), 128'd1);
            chk("drain_head", 128'(port_pkt[0 +: PKW]), 128'(exp_q.pop_front()));
            step();
            chk("drain_congestion", 128'(congestion), 128'd0);
        end
        chk("drain_empty", 128'(port_vld), 128'd0);

        // Link down on port 1 with two queued packets.
        port_rdy = 4'b1101;
        send(mk(32'd2, 32'd20, 33'd22));
        send(mk(32'd2, 32'd21, 33'd23));
        chk("link_vld_before", 128'(port_vld), 128'b0010);
        port_en = 4'b1101;
        step();
        chk("link_flushed", 128'(port_vld), 128'd0);
        chk_pulses("link_down_pulse", 3'b001);
        step();
        chk_pulses("link_down_end", 3'b000);
        port_en = 4'hF;
        step();
        chk("link_stays_empty", 128'(port_vld), 128'd0);
        chk("link_drop_cnt", 128'(drop_cnt), 128'd3);

        // Duplicate IP 2 on ports 1 and 3: lowest index wins.
        port_rdy = 4'b0000;
        port_ip  = {32'd2, 32'd3, 32'd2, 32'd1};
        p = mk(32'd2, 32'd6, 33'd8);
        send(p);
        chk("dup_port_vld", 128'(port_vld), 128'b0010);
        chk("dup_port_pkt", 128'(port_pkt[1*PKW +: PKW]), 128'(p));

        // Reset while a packet is in CHECK.
        port_wan_vld = 1'b1;
        port_wan     = mk(32'd3, 32'd1, 33'd4);
        step();
        port_wan_vld = 1'b0;
        rst          = 1'b1;
        #1;
        chk("rst_wan_rdy", 128'(port_wan_rdy), 128'd0);
        step();
        chk("rst_port_vld", 128'(port_vld), 128'd0);
        chk("rst_drop_cnt", 128'(drop_cnt), 128'd0);
        chk_pulses("rst_pulses", 3'b000);
        rst = 1'b0;
        step();
        chk("post_rst_port_vld", 128'(port_vld), 128'd0);
        chk_pulses("post_rst_pulses", 3'b000);
        chk("post_rst_drop_cnt", 128'(drop_cnt), 128'd0);
        chk("post_rst_wan_rdy", 128'(port_wan_rdy), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
